prog_loader_ctrl: RTL and testbench

//  Sequences the copy of one program from HD storage into a fixed slot of instruction memory.

---
 rtl/prog_loader_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_prog_loader_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_ctrl
//  Description : Copies one program from HD storage into a fixed instruction
//                memory slot via an HD req/ack handshake and an imem write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_ctrl #(
    parameter int unsigned BLOCK_SIZE = 200,
    parameter int unsigned NUM_SLOTS  = 10,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4:0]           prog_id,
    input  logic [3:0]           slot,
    input  logic [7:0]           word_count,
    output logic                 hd_rd_req,
    output logic [ADDR_W-1:0]    hd_addr,
    input  logic                 hd_rd_ack,
    input  logic [DATA_W-1:0]    hd_data,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [DATA_W-1:0]    imem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [NUM_SLOTS-1:0] loaded_mask
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_req   = 3'd1;
    localparam logic [2:0] c_write = 3'd2;
    localparam logic [2:0] c_done  = 3'd3;
    localparam logic [2:0] c_err   = 3'd4;

    localparam int unsigned      c_tmo_w   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_one = 1;

    logic [2:0]           state_q, state_d;
    logic [4:0]           prog_q, prog_d;
    logic [3:0]           slot_q, slot_d;
    logic [7:0]           count_q, count_d;
    logic [7:0]           idx_q, idx_d;
    logic [c_tmo_w-1:0]   tmo_q, tmo_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [NUM_SLOTS-1:0] mask_q, mask_d;

    logic                 hd_rd_req_q, hd_rd_req_d;
    logic [ADDR_W-1:0]    hd_addr_q, hd_addr_d;
    logic                 imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]    imem_wdata_q, imem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 args_bad;

    assign args_bad = (32'(slot) >= NUM_SLOTS) || (word_count == 8'd0) ||
                      (32'(word_count) > BLOCK_SIZE);

    // State, context and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= c_idle;
            prog_q       <= '0;
            slot_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            err_code_q   <= '0;
            mask_q       <= '0;
            hd_rd_req_q  <= 1'b0;
            hd_addr_q    <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_q       <= prog_d;
            slot_q       <= slot_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            err_code_q   <= err_code_d;
            mask_q       <= mask_d;
            hd_rd_req_q  <= hd_rd_req_d;
            hd_addr_q    <= hd_addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state and load context
    always_comb begin
        state_d    = state_q;
        prog_d     = prog_q;
        slot_d     = slot_q;
        count_d    = count_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        err_code_d = err_code_q;
        mask_d     = mask_q;
        case (state_q)
            c_idle: begin
                if (start && !abort) begin
                    prog_d     = prog_id;
                    slot_d     = slot;
                    count_d    = word_count;
                    idx_d      = '0;
                    tmo_d      = '0;
                    err_code_d = 2'b00;
                    if (args_bad) begin
                        state_d    = c_err;
                        err_code_d = 2'b01;
                    end else begin
                        state_d      = c_req;
                        mask_d[slot] = 1'b0;
                    end
                end
            end
            c_req: begin
                if (abort) begin
                    state_d = c_idle;
                end else if (hd_rd_ack) begin
                    state_d = c_write;
                end else if (32'(tmo_q) == TIMEOUT - 1) begin
                    state_d    = c_err;
                    err_code_d = 2'b10;
                end else begin
                    tmo_d = tmo_q + c_tmo_one;
                end
            end
            c_write: begin
                if (abort) begin
                    state_d = c_idle;
                end else if (idx_q == count_q - 8'd1) begin
                    state_d        = c_done;
                    mask_d[slot_q] = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    tmo_d   = '0;
                    state_d = c_req;
                end
            end
            c_done:  state_d = c_idle;
            c_err:   state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it
    always_comb begin
        hd_rd_req_d  = (state_d == c_req);
        hd_addr_d    = '0;
        imem_we_d    = (state_d == c_write);
        imem_addr_d  = '0;
        imem_wdata_d = '0;
        busy_d       = (state_d != c_idle);
        done_d       = (state_d == c_done);
        error_d      = (state_d == c_err);
        if (state_d == c_req) begin
            hd_addr_d = ADDR_W'(prog_d) * ADDR_W'(BLOCK_SIZE) + ADDR_W'(idx_d);
        end
        if (state_d == c_write) begin
            imem_addr_d  = ADDR_W'(slot_d) * ADDR_W'(BLOCK_SIZE) + ADDR_W'(idx_d);
            imem_wdata_d = hd_data;
        end
    end

    assign hd_rd_req   = hd_rd_req_q;
    assign hd_addr     = hd_addr_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign loaded_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader_ctrl
//  Description : Directed self-checking bench for prog_loader_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader_ctrl;

    localparam int c_aw = 32;
    localparam int c_dw = 32;
    localparam int c_ns = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [4:0]        prog_id;
    logic [3:0]        slot;
    logic [7:0]        word_count;
    logic              hd_rd_req;
    logic [c_aw-1:0]   hd_addr;
    logic              hd_rd_ack;
    logic [c_dw-1:0]   hd_data;
    logic              imem_we;
    logic [c_aw-1:0]   imem_addr;
    logic [c_dw-1:0]   imem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [c_ns-1:0]   loaded_mask;

    prog_loader_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .prog_id     (prog_id),
        .slot        (slot),
        .word_count  (word_count),
        .hd_rd_req   (hd_rd_req),
        .hd_addr     (hd_addr),
        .hd_rd_ack   (hd_rd_ack),
        .hd_data     (hd_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .loaded_mask (loaded_mask)
    );

    always #5 clock = ~clock;

    int we_cnt   = 0;
    int req_cnt  = 0;
    int done_cnt = 0;
    int n_cmp    = 0;
    int n_fail   = 0;

    always @(negedge clock) begin
        if (imem_we === 1'b1)   we_cnt++;
        if (hd_rd_req === 1'b1) req_cnt++;
        if (done === 1'b1)      done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input logic [4:0] p, input logic [3:0] s, input logic [7:0] c);
        prog_id    = p;
        slot       = s;
        word_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        int w0;
        int r0;
        int d0;
        int cyc;

        reset = 1'b1; start = 1'b0; abort = 1'b0; hd_rd_ack = 1'b0; hd_data = '0;
        prog_id = '0; slot = '0; word_count = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", hd_rd_req, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_done_err", {done, error, err_code}, 0);
        chk("rst_mask", loaded_mask, 0);
        chk("rst_addr", {hd_addr, imem_addr}, 0);
        reset = 1'b0;
        tick();

        // Basic 3-word load, ack held high throughout
        hd_rd_ack = 1'b1; hd_data = 32'hA0A0_0001;
        start_load(5'd2, 4'd1, 8'd3);
        chk("t2_req0", hd_rd_req, 1);
        chk("t2_haddr0", hd_addr, 400);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_we0", {imem_we, hd_rd_req}, 2'b10);
        chk("t2_iaddr0", imem_addr, 200);
        chk("t2_wdata0", imem_wdata, 32'hA0A0_0001);
        hd_data = 32'hB0B0_0002;
        tick();
        chk("t2_haddr1", hd_addr, 401);
        tick();
        chk("t2_iaddr1", imem_addr, 201);
        chk("t2_wdata1", imem_wdata, 32'hB0B0_0002);
        hd_data = 32'hC0C0_0003;
        tick();
        chk("t2_haddr2", hd_addr, 402);
        tick();
        chk("t2_iaddr2", imem_addr, 202);
        chk("t2_wdata2", imem_wdata, 32'hC0C0_0003);
        tick();
        chk("t2_done", {done, imem_we}, 2'b10);
        chk("t2_mask", loaded_mask, 10'b0000000010);
        tick();
        chk("t2_idle", {done, busy}, 0);
        hd_rd_ack = 1'b0;

        // Rejected arguments
        w0 = we_cnt; r0 = req_cnt;
        start_load(5'd0, 4'd10, 8'd3);
        chk("t3_slot_err", {error, err_code, busy}, 4'b1011);
        tick();
        chk("t3_err_held", {error, err_code, busy}, 4'b0010);
        start_load(5'd0, 4'd0, 8'd0);
        chk("t3_cnt0_err", {error, err_code}, 3'b101);
        tick();
        start_load(5'd0, 4'd0, 8'd201);
        chk("t3_cnt201_err", {error, err_code}, 3'b101);
        tick();
        chk("t3_no_req", req_cnt - r0, 0);
        chk("t3_no_we", we_cnt - w0, 0);
        chk("t3_mask", loaded_mask, 10'b0000000010);

        // Delayed ack into the last slot
        w0 = we_cnt; r0 = req_cnt;
        start_load(5'd1, 4'd9, 8'd1);
        chk("t4_errcode_clr", err_code, 0);
        repeat (5) tick();
        chk("t4_req_held", hd_rd_req, 1);
        chk("t4_haddr", hd_addr, 200);
        hd_rd_ack = 1'b1; hd_data = 32'hD0D0_0004;
        tick();
        hd_rd_ack = 1'b0;
        chk("t4_we", imem_we, 1);
        chk("t4_iaddr", imem_addr, 1800);
        chk("t4_wdata", imem_wdata, 32'hD0D0_0004);
        tick();
        chk("t4_done", done, 1);
        chk("t4_mask", loaded_mask, 10'b1000000010);
        tick();
        chk("t4_req_cycles", req_cnt - r0, 6);
        chk("t4_one_write", we_cnt - w0, 1);

        // Timeout, reusing slot 9 so its valid bit is dropped
        w0 = we_cnt; r0 = req_cnt;
        start_load(5'd1, 4'd9, 8'd2);
        chk("t4b_mask_clr", loaded_mask, 10'b0000000010);
        cyc = 1;
        while (error !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("t4b_tmo_lat", cyc, 17);
        chk("t4b_errcode", err_code, 2'b10);
        chk("t4b_req_cycles", req_cnt - r0, 16);
        chk("t4b_no_we", we_cnt - w0, 0);
        tick();
        chk("t4b_after", {error, busy, err_code}, 4'b0010);

        // Abort after the second write
        w0 = we_cnt; d0 = done_cnt;
        hd_rd_ack = 1'b1; hd_data = 32'hE0E0_0005;
        start_load(5'd4, 4'd3, 8'd4);
        tick(); tick(); tick();
        chk("t5_we2", imem_we, 1);
        chk("t5_iaddr2", imem_addr, 601);
        tick();
        chk("t5_haddr3", hd_addr, 802);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_idle", {busy, hd_rd_req, imem_we, done, error}, 0);
        repeat (3) tick();
        chk("t5_writes", we_cnt - w0, 2);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_mask", loaded_mask, 10'b0000000010);

        // start while busy, then start together with abort in IDLE
        hd_data = 32'hF0F0_0006;
        start_load(5'd3, 4'd4, 8'd2);
        chk("t6_haddr0", hd_addr, 600);
        prog_id = 5'd0; slot = 4'd9; word_count = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_iaddr0", imem_addr, 800);
        chk("t6_wdata0", imem_wdata, 32'hF0F0_0006);
        tick();
        chk("t6_haddr1", hd_addr, 601);
        tick();
        chk("t6_iaddr1", imem_addr, 801);
        tick();
        chk("t6_done", done, 1);
        chk("t6_mask", loaded_mask, 10'b0000010010);
        tick();
        r0 = req_cnt;
        abort = 1'b1;
        start_load(5'd0, 4'd5, 8'd1);
        abort = 1'b0;
        chk("t6_abort_wins", {busy, hd_rd_req, error}, 0);
        tick();
        chk("t6_still_idle", busy, 0);
        chk("t6_no_req", req_cnt - r0, 0);
        chk("t6_mask_kept", loaded_mask, 10'b0000010010);

        // Asynchronous reset mid-load
        start_load(5'd0, 4'd5, 8'd3);
        tick();
        chk("t7_in_write", imem_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("t7_async", {busy, hd_rd_req, imem_we, done, error, err_code}, 0);
        chk("t7_mask", loaded_mask, 0);
        chk("t7_addr", {imem_addr, imem_wdata}, 0);
        reset = 1'b0;
        hd_rd_ack = 1'b0;
        tick(); tick();
        chk("t7_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
